// File: rtl/shape_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : shape_sequencer
// Description : LFSR-driven Tetris piece generator feeding a shared ring
//               buffer read by PLAYERS independent channels.
// Revision    : 1.0 - initial release
// ============================================================================
module shape_sequencer #(
    parameter int                LFSR_W     = 16,
    parameter logic [LFSR_W-1:0] TAPS       = 16'hB400,
    parameter logic [LFSR_W-1:0] SEED       = 16'hACE1,
    parameter int                DEPTH      = 8,
    parameter int                PLAYERS    = 2,
    parameter int                NUM_SHAPES = 7
) (
    input  logic                   Clk,
    input  logic                   rst,
    input  logic                   seed_load,
    input  logic [LFSR_W-1:0]      seed_val,
    input  logic [PLAYERS-1:0]     change_shape,
    output logic [3*PLAYERS-1:0]   curr_shape,
    output logic [3*PLAYERS-1:0]   next_shape,
    output logic [PLAYERS-1:0]     shape_valid
);

    localparam int         c_AW         = $clog2(DEPTH);
    localparam int         c_PW         = c_AW + 1;
    localparam logic [3:0] c_NUM_SHAPES = 4'(NUM_SHAPES);

    logic [LFSR_W-1:0]              r_lfsr;
    logic [2:0]                     r_buf [DEPTH];
    logic [c_PW-1:0]                r_wp;
    logic [PLAYERS-1:0][c_PW-1:0]   r_rp;

    logic                           w_fb;
    logic [2:0]                     w_cand;
    logic                           w_accept;
    logic                           w_full;
    logic                           w_write;
    logic [c_PW-1:0]                w_occ    [PLAYERS];
    logic [c_AW-1:0]                w_nidx   [PLAYERS];
    logic [PLAYERS-1:0]             w_valid;
    logic [PLAYERS-1:0]             w_at_cap;

    assign w_fb     = ^(r_lfsr & TAPS);
    assign w_cand   = r_lfsr[2:0];
    assign w_accept = ({1'b0, w_cand} < c_NUM_SHAPES);
    // Full is judged against the slowest reader so no unread entry is overwritten.
    assign w_full   = |w_at_cap;
    assign w_write  = w_accept && !w_full;

    generate
        for (genvar p = 0; p < PLAYERS; p++) begin : g_player
            assign w_occ[p]               = r_wp - r_rp[p];
            assign w_valid[p]             = (w_occ[p] >= c_PW'(2));
            assign w_at_cap[p]            = (w_occ[p] == c_PW'(DEPTH));
            assign w_nidx[p]              = r_rp[p][c_AW-1:0] + c_AW'(1);
            assign curr_shape[3*p +: 3]   = r_buf[r_rp[p][c_AW-1:0]];
            assign next_shape[3*p +: 3]   = r_buf[w_nidx[p]];
        end
    endgenerate

    assign shape_valid = w_valid;

    always_ff @(posedge Clk) begin
        if (rst) begin
            r_lfsr <= SEED;
            r_wp   <= '0;
            r_rp   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_buf[i] <= '0;
            end
        end else if (seed_load) begin
            // A zero seed would lock the LFSR, so fall back to the default seed.
            r_lfsr <= (seed_val == '0) ? SEED : seed_val;
            r_wp   <= '0;
            r_rp   <= '0;
        end else begin
            r_lfsr <= {r_lfsr[LFSR_W-2:0], w_fb};
            if (w_write) begin
                r_buf[r_wp[c_AW-1:0]] <= w_cand;
                r_wp                  <= r_wp + c_PW'(1);
            end
            for (int p = 0; p < PLAYERS; p++) begin
                if (change_shape[p] && w_valid[p]) begin
                    r_rp[p] <= r_rp[p] + c_PW'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_shape_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_shape_sequencer
// Description : Self-checking bench for shape_sequencer against a count-based
//               reference model of the piece stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shape_sequencer;

    localparam int          c_PLAYERS = 2;
    localparam int          c_DEPTH   = 8;
    localparam logic [15:0] c_SEED    = 16'hACE1;
    localparam logic [15:0] c_TAPS    = 16'hB400;

    logic                     Clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     seed_load = 1'b0;
    logic [15:0]              seed_val = '0;
    logic [c_PLAYERS-1:0]     change_shape = '0;
    logic [3*c_PLAYERS-1:0]   curr_shape;
    logic [3*c_PLAYERS-1:0]   next_shape;
    logic [c_PLAYERS-1:0]     shape_valid;

    int n_cmp = 0;
    int n_err = 0;

    // Model: pieces written since the last load/reset are counted, not pointed to.
    logic [15:0] m_lfsr;
    logic [2:0]  m_mem [c_DEPTH];
    int          m_w;
    int          m_r [c_PLAYERS];

    shape_sequencer #(
        .LFSR_W     (16),
        .TAPS       (c_TAPS),
        .SEED       (c_SEED),
        .DEPTH      (c_DEPTH),
        .PLAYERS    (c_PLAYERS),
        .NUM_SHAPES (7)
    ) dut (
        .Clk          (Clk),
        .rst          (rst),
        .seed_load    (seed_load),
        .seed_val     (seed_val),
        .change_shape (change_shape),
        .curr_shape   (curr_shape),
        .next_shape   (next_shape),
        .shape_valid  (shape_valid)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        int  lag;
        bit  full;
        bit  adv [c_PLAYERS];
        int  cand;
        if (rst) begin
            m_lfsr = c_SEED;
            m_w    = 0;
            foreach (m_r[p]) m_r[p] = 0;
            foreach (m_mem[i]) m_mem[i] = 3'd0;
        end else if (seed_load) begin
            m_lfsr = (seed_val == 16'd0) ? c_SEED : seed_val;
            m_w    = 0;
            foreach (m_r[p]) m_r[p] = 0;
        end else begin
            full = 1'b0;
            for (int p = 0; p < c_PLAYERS; p++) begin
                lag    = m_w - m_r[p];
                adv[p] = change_shape[p] && (lag >= 2);
                if (lag == c_DEPTH) full = 1'b1;
            end
            cand = m_lfsr % 8;
            if (cand < 7 && !full) begin
                m_mem[m_w % c_DEPTH] = 3'(cand);
                m_w++;
            end
            for (int p = 0; p < c_PLAYERS; p++)
                if (adv[p]) m_r[p]++;
            m_lfsr = {m_lfsr[14:0], ^(m_lfsr & c_TAPS)};
        end
    endtask

    task automatic check_outputs();
        for (int p = 0; p < c_PLAYERS; p++) begin
            chk($sformatf("valid[%0d]", p), 32'(shape_valid[p]), 32'((m_w - m_r[p]) >= 2));
            chk($sformatf("curr[%0d]", p), 32'(curr_shape[3*p +: 3]), 32'(m_mem[m_r[p] % c_DEPTH]));
            chk($sformatf("next[%0d]", p), 32'(next_shape[3*p +: 3]), 32'(m_mem[(m_r[p] + 1) % c_DEPTH]));
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge Clk);
        #1;
        check_outputs();
    endtask

    task automatic load_seed(input logic [15:0] s, input logic [1:0] chg);
        seed_load    = 1'b1;
        seed_val     = s;
        change_shape = chg;
        tick();
        seed_load    = 1'b0;
        change_shape = '0;
    endtask

    initial begin
        // Reset and initial state
        rst = 1'b1;
        tick();
        tick();
        chk("rst_lfsr", 32'(dut.r_lfsr), 32'h0000ACE1);
        chk("rst_curr", 32'(curr_shape), 32'd0);
        chk("rst_next", 32'(next_shape), 32'd0);
        chk("rst_valid", 32'(shape_valid), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 30; i++) begin
            change_shape = 2'($urandom_range(0, 3));
            tick();
        end

        // Reset mid-sequence
        rst = 1'b1;
        change_shape = 2'b11;
        tick();
        tick();
        chk("rst2_lfsr", 32'(dut.r_lfsr), 32'h0000ACE1);
        chk("rst2_curr", 32'(curr_shape), 32'd0);
        chk("rst2_valid", 32'(shape_valid), 32'd0);
        rst = 1'b0;
        change_shape = '0;

        // Seed 1: buffer fills 1, 2, 4, 0
        load_seed(16'h0001, 2'b00);
        chk("s1_valid0", 32'(shape_valid), 32'd0);
        tick();
        tick();
        chk("s1_valid", 32'(shape_valid), 32'd3);
        chk("s1_curr", 32'(curr_shape), {26'd0, 3'd1, 3'd1});
        chk("s1_next", 32'(next_shape), {26'd0, 3'd2, 3'd2});

        // Rejection: candidate 7 dropped, then 6, 4
        load_seed(16'h0007, 2'b00);
        tick();
        tick();
        chk("s7_valid_early", 32'(shape_valid), 32'd0);
        tick();
        chk("s7_valid", 32'(shape_valid), 32'd3);
        chk("s7_curr", 32'(curr_shape), {26'd0, 3'd6, 3'd6});
        chk("s7_next", 32'(next_shape), {26'd0, 3'd4, 3'd4});

        // Zero seed substitutes the reset seed
        load_seed(16'h0000, 2'b00);
        chk("s0_lfsr", 32'(dut.r_lfsr), 32'h0000ACE1);
        for (int i = 0; i < 20; i++) begin
            change_shape = 2'($urandom_range(0, 3));
            tick();
        end

        // Full/lag: player 1 idle, player 0 streams
        load_seed(16'h0001, 2'b00);
        change_shape = 2'b01;
        for (int i = 0; i < 24; i++) tick();
        chk("lag_wp", 32'(dut.r_wp), 32'd8);
        chk("lag_rp0", 32'(dut.r_rp[0]), 32'd7);
        chk("lag_valid0", 32'(shape_valid[0]), 32'd0);
        change_shape = 2'b10;
        tick();
        change_shape = 2'b01;
        for (int i = 0; i < 10; i++) tick();
        chk("lag_wp_after", 32'(dut.r_wp), 32'd9);
        change_shape = 2'b00;

        // Simultaneous advance with writes
        load_seed(16'h0001, 2'b00);
        tick();
        tick();
        change_shape = 2'b11;
        tick();
        chk("sim_rp0", 32'(dut.r_rp[0]), 32'd1);
        chk("sim_rp1", 32'(dut.r_rp[1]), 32'd1);
        chk("sim_wp", 32'(dut.r_wp), 32'd3);

        // Seed load with coincident advances
        load_seed(16'h1234, 2'b11);
        chk("ld_wp", 32'(dut.r_wp), 32'd0);
        chk("ld_rp", 32'(dut.r_rp), 32'd0);
        chk("ld_valid", 32'(shape_valid), 32'd0);

        // Random soak with occasional reseeding
        for (int i = 0; i < 400; i++) begin
            change_shape = 2'($urandom_range(0, 3));
            seed_load    = ($urandom_range(0, 39) == 0);
            seed_val     = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            tick();
        end
        seed_load    = 1'b0;
        change_shape = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
